// File: rtl/tl_resp_pkg.sv
// Shared TileLink-UL constants and FSM state type for the TL-UL memory responder.
package tl_resp_pkg;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } tl_state_e;

    // Low address bits that must be zero for a naturally aligned access of 2**size bytes.
    function automatic logic [2:0] size_align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tl_resp_mem.sv
// DEPTH x 64-bit byte-masked register file: one write port, one combinational read port,
// asynchronous active-low clear of every word.
module tl_resp_mem
    import tl_resp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [7:0]       i_wmask,
    input  logic [63:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [63:0]      o_rdata
);

    logic [63:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tl_ul_responder.sv
// TL-UL single-beat memory responder: one outstanding request, fixed A-to-D latency,
// denies unsupported, misaligned or out-of-range accesses without touching the store.
module tl_ul_responder
    import tl_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
    parameter int          DEPTH     = 16,
    parameter int          LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tl_slave_a_valid,
    output logic        tl_slave_a_ready,
    input  logic [2:0]  tl_slave_a_bits_opcode,
    input  logic [2:0]  tl_slave_a_bits_param,
    input  logic [3:0]  tl_slave_a_bits_size,
    input  logic [1:0]  tl_slave_a_bits_source,
    input  logic [31:0] tl_slave_a_bits_address,
    input  logic [7:0]  tl_slave_a_bits_mask,
    input  logic [63:0] tl_slave_a_bits_data,
    input  logic        tl_slave_a_bits_corrupt,
    output logic        tl_slave_d_valid,
    input  logic        tl_slave_d_ready,
    output logic [2:0]  tl_slave_d_bits_opcode,
    output logic [1:0]  tl_slave_d_bits_param,
    output logic [3:0]  tl_slave_d_bits_size,
    output logic [1:0]  tl_slave_d_bits_source,
    output logic [1:0]  tl_slave_d_bits_sink,
    output logic        tl_slave_d_bits_denied,
    output logic [63:0] tl_slave_d_bits_data,
    output logic        tl_slave_d_bits_corrupt,
    output tl_state_e   o_dbg_state
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH * 8);
    localparam logic [2:0]  CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    // A fires only in IDLE; D fires only in RESP. Both follow valid & ready with the
    // sender holding its payload stable while valid is high and ready is low.
    tl_state_e   r_state, w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  r_d_opcode;
    logic [3:0]  r_d_size;
    logic [1:0]  r_d_source;
    logic        r_d_denied;
    logic        r_d_corrupt;
    logic [63:0] r_d_data;

    logic [32:0]      w_offset;
    logic             w_in_range;
    logic             w_size_ok;
    logic             w_aligned;
    logic             w_is_get;
    logic             w_is_put;
    logic             w_denied;
    logic             w_a_fire;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_idx;
    logic [63:0]      w_rdata;
    logic             w_unused;

    assign w_offset   = {1'b0, tl_slave_a_bits_address} - {1'b0, BASE_ADDR};
    assign w_in_range = !w_offset[32] && (w_offset < SPAN);
    assign w_idx      = w_offset[IDX_W+2:3];
    assign w_size_ok  = (tl_slave_a_bits_size[3:2] == 2'b00);
    assign w_aligned  = (tl_slave_a_bits_address[2:0] &
                         size_align_mask(tl_slave_a_bits_size[1:0])) == 3'b000;
    assign w_is_get   = (tl_slave_a_bits_opcode == TL_A_GET);
    assign w_is_put   = (tl_slave_a_bits_opcode == TL_A_PUT_FULL) ||
                        (tl_slave_a_bits_opcode == TL_A_PUT_PARTIAL);
    assign w_denied   = !(w_is_get || w_is_put) || !w_size_ok || !w_aligned || !w_in_range;
    assign w_a_fire   = tl_slave_a_valid && tl_slave_a_ready;
    assign w_mem_we   = w_a_fire && w_is_put && !w_denied;
    assign w_unused   = ^{tl_slave_a_bits_param, tl_slave_a_bits_corrupt, w_offset[2:0]};

    tl_resp_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_we    (w_mem_we),
        .i_waddr (w_idx),
        .i_wmask (tl_slave_a_bits_mask),
        .i_wdata (tl_slave_a_bits_data),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (tl_slave_a_valid) w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 3'd0)    w_state_nxt = ST_RESP;
            ST_RESP: if (tl_slave_d_ready) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_a_fire) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Response header and data are frozen at A-fire so they stay stable through D back-pressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_d_opcode  <= 3'd0;
            r_d_size    <= 4'd0;
            r_d_source  <= 2'd0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= 64'd0;
        end else if (w_a_fire) begin
            r_d_opcode  <= w_is_get ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
            r_d_size    <= tl_slave_a_bits_size;
            r_d_source  <= tl_slave_a_bits_source;
            r_d_denied  <= w_denied;
            r_d_corrupt <= w_denied && w_is_get;
            r_d_data    <= (w_is_get && !w_denied) ? w_rdata : 64'd0;
        end
    end

    assign tl_slave_a_ready        = (r_state == ST_IDLE);
    assign tl_slave_d_valid        = (r_state == ST_RESP);
    assign tl_slave_d_bits_opcode  = r_d_opcode;
    assign tl_slave_d_bits_param   = 2'd0;
    assign tl_slave_d_bits_size    = r_d_size;
    assign tl_slave_d_bits_source  = r_d_source;
    assign tl_slave_d_bits_sink    = 2'd0;
    assign tl_slave_d_bits_denied  = r_d_denied;
    assign tl_slave_d_bits_data    = r_d_data;
    assign tl_slave_d_bits_corrupt = r_d_corrupt;
    assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_tl_ul_responder.sv
// Directed bench for tl_ul_responder: three instances with LATENCY 1, 4 and 3.
module tb_tl_ul_responder;
    import tl_resp_pkg::*;

    localparam logic [31:0] BASE = 32'h7000_0000;
    localparam int          W    = 66;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  a_op;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_src;
    logic [31:0] a_addr;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_cor;

    logic        a_valid [3];
    logic        a_ready [3];
    logic        d_valid [3];
    logic        d_ready [3];
    logic [2:0]  d_op    [3];
    logic [1:0]  d_param [3];
    logic [3:0]  d_size  [3];
    logic [1:0]  d_src   [3];
    logic [1:0]  d_sink  [3];
    logic        d_den   [3];
    logic [63:0] d_data  [3];
    logic        d_cor   [3];
    tl_state_e   dbg     [3];

    logic [W-1:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tl_ul_responder #(
            .BASE_ADDR (BASE),
            .DEPTH     (16),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 4 : 3))
        ) u_dut (
            .clock                   (clock),
            .reset                   (reset),
            .tl_slave_a_valid        (a_valid[g]),
            .tl_slave_a_ready        (a_ready[g]),
            .tl_slave_a_bits_opcode  (a_op),
            .tl_slave_a_bits_param   (a_param),
            .tl_slave_a_bits_size    (a_size),
            .tl_slave_a_bits_source  (a_src),
            .tl_slave_a_bits_address (a_addr),
            .tl_slave_a_bits_mask    (a_mask),
            .tl_slave_a_bits_data    (a_data),
            .tl_slave_a_bits_corrupt (a_cor),
            .tl_slave_d_valid        (d_valid[g]),
            .tl_slave_d_ready        (d_ready[g]),
            .tl_slave_d_bits_opcode  (d_op[g]),
            .tl_slave_d_bits_param   (d_param[g]),
            .tl_slave_d_bits_size    (d_size[g]),
            .tl_slave_d_bits_source  (d_src[g]),
            .tl_slave_d_bits_sink    (d_sink[g]),
            .tl_slave_d_bits_denied  (d_den[g]),
            .tl_slave_d_bits_data    (d_data[g]),
            .tl_slave_d_bits_corrupt (d_cor[g]),
            .o_dbg_state             (dbg[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_a(input int u, input logic [2:0] op, input logic [3:0] sz,
                          input logic [1:0] src, input logic [31:0] addr,
                          input logic [7:0] msk, input logic [63:0] dat);
        a_op   = op;
        a_size = sz;
        a_src  = src;
        a_addr = addr;
        a_mask = msk;
        a_data = dat;
        a_valid[u] = 1'b1;
        @(posedge clock); #1;
        a_valid[u] = 1'b0;
    endtask

    task automatic wait_dv(input int u, output int lat);
        lat = 1;
        while (!d_valid[u] && lat < 32) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic d_fire(input int u);
        d_ready[u] = 1'b1;
        @(posedge clock); #1;
        d_ready[u] = 1'b0;
    endtask

    task automatic xact(input int u, input string tag, input logic [2:0] op, input logic [3:0] sz,
                        input logic [1:0] src, input logic [31:0] addr, input logic [7:0] msk,
                        input logic [63:0] dat, input logic [2:0] e_op, input logic e_den,
                        input logic e_cor, input logic [63:0] e_data, input int e_lat);
        int lat;
        chk({tag, ":a_ready_pre"}, 64'(a_ready[u]), 64'(1));
        send_a(u, op, sz, src, addr, msk, dat);
        wait_dv(u, lat);
        chk({tag, ":latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ":d_valid"}, 64'(d_valid[u]), 64'(1));
        chk({tag, ":opcode"}, 64'(d_op[u]), 64'(e_op));
        chk({tag, ":denied"}, 64'(d_den[u]), 64'(e_den));
        chk({tag, ":corrupt"}, 64'(d_cor[u]), 64'(e_cor));
        chk({tag, ":data"}, d_data[u], e_data);
        chk({tag, ":source"}, 64'(d_src[u]), 64'(src));
        chk({tag, ":size"}, 64'(d_size[u]), 64'(sz));
        chk({tag, ":param_sink"}, 64'({d_param[u], d_sink[u]}), 64'(0));
        d_fire(u);
        chk({tag, ":idle_after"}, 64'({a_ready[u], d_valid[u]}), 64'(2'b10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int last_fire;
        int n_resp;
        int idx;
        logic rdy_prev;
        logic any_dv;
        logic [63:0] snap;
        logic [W-1:0] e;
        logic [31:0] b2b_addr [4];
        logic [63:0] b2b_data [4];

        a_op = 3'd0; a_param = 3'd0; a_size = 4'd0; a_src = 2'd0;
        a_addr = 32'd0; a_mask = 8'd0; a_data = 64'd0; a_cor = 1'b0;
        for (int u = 0; u < 3; u++) begin
            a_valid[u] = 1'b0;
            d_ready[u] = 1'b0;
        end

        repeat (2) @(posedge clock);
        #1;
        chk("rst:a_ready", 64'(a_ready[0]), 64'(1));
        chk("rst:d_valid", 64'(d_valid[0]), 64'(0));
        chk("rst:d_bits", {d_data[0][59:0], d_op[0], d_den[0]}, 64'(0));
        chk("rst:state", 64'(dbg[0]), 64'(ST_IDLE));
        reset = 1'b1;
        @(posedge clock); #1;

        xact(0, "get_after_rst", TL_A_GET, 4'd3, 2'd1, BASE, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0, 64'd0, 1);
        xact(0, "put_full", TL_A_PUT_FULL, 4'd3, 2'd2, BASE + 32'h8, 8'hFF,
             64'h1122334455667788, TL_D_ACCESS_ACK, 1'b0, 1'b0, 64'd0, 1);
        xact(0, "put_partial", TL_A_PUT_PARTIAL, 4'd0, 2'd3, BASE + 32'h8, 8'h01,
             64'h00000000000000AA, TL_D_ACCESS_ACK, 1'b0, 1'b0, 64'd0, 1);
        xact(0, "get_merged", TL_A_GET, 4'd3, 2'd0, BASE + 32'h8, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0, 64'h11223344556677AA, 1);
        xact(0, "put_last_word", TL_A_PUT_PARTIAL, 4'd3, 2'd1, BASE + 32'h78, 8'hF0,
             64'hDEADBEEFCAFEF00D, TL_D_ACCESS_ACK, 1'b0, 1'b0, 64'd0, 1);
        xact(0, "get_last_sz2", TL_A_GET, 4'd2, 2'd2, BASE + 32'h7C, 8'hF0, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0, 64'hDEADBEEF00000000, 1);
        xact(0, "get_past_end", TL_A_GET, 4'd3, 2'd3, BASE + 32'h80, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b1, 1'b1, 64'd0, 1);
        xact(0, "get_misaligned", TL_A_GET, 4'd3, 2'd0, BASE + 32'h4, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b1, 1'b1, 64'd0, 1);
        xact(0, "get_below_base", TL_A_GET, 4'd3, 2'd1, BASE - 32'h8, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b1, 1'b1, 64'd0, 1);
        xact(0, "get_size4", TL_A_GET, 4'd4, 2'd2, BASE, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b1, 1'b1, 64'd0, 1);
        xact(0, "get_sz1_odd", TL_A_GET, 4'd1, 2'd3, BASE + 32'h1, 8'h03, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b1, 1'b1, 64'd0, 1);
        xact(0, "opcode2", 3'd2, 4'd3, 2'd1, BASE + 32'h8, 8'hFF, 64'hFFFFFFFFFFFFFFFF,
             TL_D_ACCESS_ACK, 1'b1, 1'b0, 64'd0, 1);
        xact(0, "put_misaligned", TL_A_PUT_FULL, 4'd3, 2'd2, BASE + 32'hC, 8'hFF,
             64'hFFFFFFFFFFFFFFFF, TL_D_ACCESS_ACK, 1'b1, 1'b0, 64'd0, 1);
        xact(0, "get_unchanged", TL_A_GET, 4'd3, 2'd3, BASE + 32'h8, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0, 64'h11223344556677AA, 1);

        // LATENCY 4 with D back-pressure and an A request offered while busy
        xact(1, "l4_put", TL_A_PUT_FULL, 4'd3, 2'd0, BASE + 32'h10, 8'hFF,
             64'h0123456789ABCDEF, TL_D_ACCESS_ACK, 1'b0, 1'b0, 64'd0, 4);
        send_a(1, TL_A_GET, 4'd3, 2'd2, BASE + 32'h10, 8'hFF, 64'd0);
        lat = 1;
        while (!d_valid[1] && lat < 32) begin
            chk("l4:a_ready_wait", 64'(a_ready[1]), 64'(0));
            @(posedge clock); #1;
            lat++;
        end
        chk("l4:latency", 64'(lat), 64'(4));
        snap = d_data[1];
        chk("l4:data", snap, 64'h0123456789ABCDEF);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) a_valid[1] = 1'b1;
            chk("l4:hold_valid", 64'(d_valid[1]), 64'(1));
            chk("l4:hold_data", d_data[1], snap);
            chk("l4:hold_hdr", 64'({d_op[1], d_src[1], d_size[1]}),
                64'({TL_D_ACCESS_ACK_DATA, 2'd2, 4'd3}));
            chk("l4:a_ready_hold", 64'(a_ready[1]), 64'(0));
            @(posedge clock); #1;
        end
        d_ready[1] = 1'b1;
        @(posedge clock); #1;
        d_ready[1] = 1'b0;
        a_valid[1] = 1'b0;
        chk("l4:idle_after_dfire", 64'(dbg[1]), 64'(ST_IDLE));
        any_dv = 1'b0;
        for (int c = 0; c < 8; c++) begin
            any_dv = any_dv | d_valid[1];
            @(posedge clock); #1;
        end
        chk("l4:no_extra_beat", 64'(any_dv), 64'(0));

        // back-to-back Gets with d_ready tied high
        b2b_addr[0] = BASE + 32'h8;  b2b_data[0] = 64'h11223344556677AA;
        b2b_addr[1] = BASE + 32'h78; b2b_data[1] = 64'hDEADBEEF00000000;
        b2b_addr[2] = BASE + 32'h8;  b2b_data[2] = 64'h11223344556677AA;
        b2b_addr[3] = BASE;          b2b_data[3] = 64'd0;
        d_ready[0] = 1'b1;
        idx = 0;
        a_op = TL_A_GET; a_size = 4'd3; a_mask = 8'hFF;
        a_src = 2'd0; a_addr = b2b_addr[0];
        a_valid[0] = 1'b1;
        rdy_prev = a_ready[0];
        last_fire = -1;
        n_resp = 0;
        for (int cyc = 0; cyc < 40 && n_resp < 4; cyc++) begin
            @(posedge clock); #1;
            if (a_valid[0] && rdy_prev) begin
                exp_q.push_back({a_src, b2b_data[idx]});
                if (last_fire >= 0) chk("b2b:interval", 64'(cyc - last_fire), 64'(2));
                last_fire = cyc;
                idx++;
                if (idx < 4) begin
                    a_src  = 2'(idx);
                    a_addr = b2b_addr[idx];
                end else begin
                    a_valid[0] = 1'b0;
                end
            end
            if (d_valid[0]) begin
                if (exp_q.size() == 0) begin
                    chk("b2b:unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("b2b:source", 64'(d_src[0]), 64'(e[65:64]));
                    chk("b2b:data", d_data[0], e[63:0]);
                end
                n_resp++;
            end
            rdy_prev = a_ready[0];
        end
        a_valid[0] = 1'b0;
        d_ready[0] = 1'b0;
        chk("b2b:count", 64'(n_resp), 64'(4));

        // LATENCY 3: reset during WAIT drops the pending response and clears the store
        xact(2, "l3_put", TL_A_PUT_FULL, 4'd3, 2'd0, BASE + 32'h8, 8'hFF,
             64'hA5A5A5A5A5A5A5A5, TL_D_ACCESS_ACK, 1'b0, 1'b0, 64'd0, 3);
        send_a(2, TL_A_GET, 4'd3, 2'd1, BASE + 32'h8, 8'hFF, 64'd0);
        chk("l3:in_wait", 64'(dbg[2]), 64'(ST_WAIT));
        reset = 1'b0;
        #1;
        chk("l3:rst_a_ready", 64'(a_ready[2]), 64'(1));
        chk("l3:rst_d_valid", 64'(d_valid[2]), 64'(0));
        chk("l3:rst_source", 64'(d_src[2]), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        any_dv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            any_dv = any_dv | d_valid[2];
            @(posedge clock); #1;
        end
        chk("l3:no_stale_beat", 64'(any_dv), 64'(0));
        xact(2, "l3_get_after_rst", TL_A_GET, 4'd3, 2'd3, BASE + 32'h8, 8'hFF, 64'd0,
             TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0, 64'd0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
